// File: rtl/buffer_access_ctrl.sv
// Shares one 64-bit word buffer between a DMA-side loader (word writes) and a
// PE-side reader (byte/word reads). Round-robin arbitration, one op in flight.
module buffer_access_ctrl #(
    parameter int BuffDepth = 256,
    parameter int ByteAddrW = $clog2(BuffDepth),
    parameter int WordAddrW = $clog2(BuffDepth / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [WordAddrW-1:0] ld_addr,
    input  logic [63:0]          ld_data,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic                 rd_mode,
    input  logic [ByteAddrW-1:0] rd_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic                 buf_write_en,
    output logic                 buf_read_en,
    output logic                 buf_addr_mode,
    output logic [ByteAddrW-1:0] buf_byte_addr,
    output logic [WordAddrW-1:0] buf_word_addr,
    output logic [63:0]          buf_word_in,
    output logic [7:0]           buf_byte_in,
    input  logic [63:0]          buf_word_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    typedef struct packed {
        logic                 is_rd;
        logic                 word_mode;
        logic [WordAddrW-1:0] widx;
        logic [2:0]           off;
        logic [63:0]          wdata;
    } req_t;

    localparam logic GNT_LD = 1'b0;
    localparam logic GNT_RD = 1'b1;

    state_t state, state_nxt;
    req_t   req;
    logic   last_grant;
    logic   ld_gnt, rd_gnt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grants are only issued from IDLE; on a tie the side not served last wins.
    always_comb begin
        state_nxt = state;
        ld_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        case (state)
            IDLE: begin
                if (ld_valid && (!rd_valid || last_grant == GNT_RD)) ld_gnt = 1'b1;
                else if (rd_valid)                                   rd_gnt = 1'b1;
                if (ld_gnt || rd_gnt) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = req.is_rd ? CAPT : IDLE;
            CAPT:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ld_ready = ld_gnt;
    assign rd_ready = rd_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= GNT_RD;
            req          <= '0;
            buf_write_en <= 1'b0;
            buf_read_en  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
        end else begin
            // Strobes are high exactly for the ISSUE cycle following a grant.
            buf_write_en <= ld_gnt;
            buf_read_en  <= rd_gnt;
            if (ld_gnt) begin
                last_grant <= GNT_LD;
                req.is_rd  <= 1'b0;
                req.widx   <= ld_addr;
                req.wdata  <= ld_data;
            end
            if (rd_gnt) begin
                last_grant    <= GNT_RD;
                req.is_rd     <= 1'b1;
                req.word_mode <= rd_mode;
                req.widx      <= rd_addr[ByteAddrW-1:3];
                req.off       <= rd_addr[2:0];
            end
            if (state == CAPT) begin
                rsp_valid <= 1'b1;
                rsp_data  <= req.word_mode ? buf_word_out
                                           : {56'd0, buf_word_out[{req.off, 3'b000} +: 8]};
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // The buffer is always driven in word mode; address buses track the captured index.
    assign buf_addr_mode = 1'b1;
    assign buf_byte_in   = 8'd0;
    assign buf_word_addr = req.widx;
    assign buf_byte_addr = {req.widx, 3'b000};
    assign buf_word_in   = req.wdata;

endmodule

// File: tb/tb_buffer_access_ctrl.sv
// Directed bench for buffer_access_ctrl with a behavioural word buffer attached.
module tb_buffer_access_ctrl;
    localparam int BuffDepth = 256;
    localparam int ByteAddrW = 8;
    localparam int WordAddrW = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 ld_valid = 1'b0, ld_ready;
    logic [WordAddrW-1:0] ld_addr = '0;
    logic [63:0]          ld_data = '0;
    logic                 rd_valid = 1'b0, rd_ready, rd_mode = 1'b0;
    logic [ByteAddrW-1:0] rd_addr = '0;
    logic                 rsp_valid, rsp_ready = 1'b1;
    logic [63:0]          rsp_data;
    logic                 buf_write_en, buf_read_en, buf_addr_mode;
    logic [ByteAddrW-1:0] buf_byte_addr;
    logic [WordAddrW-1:0] buf_word_addr;
    logic [63:0]          buf_word_in, buf_word_out;
    logic [7:0]           buf_byte_in;

    int errs = 0;
    int checks = 0;

    buffer_access_ctrl #(.BuffDepth(BuffDepth)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_mode(rd_mode), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .buf_write_en(buf_write_en), .buf_read_en(buf_read_en), .buf_addr_mode(buf_addr_mode),
        .buf_byte_addr(buf_byte_addr), .buf_word_addr(buf_word_addr),
        .buf_word_in(buf_word_in), .buf_byte_in(buf_byte_in), .buf_word_out(buf_word_out)
    );

    always #5 clk = ~clk;

    // Word buffer: read data appears the cycle after read_en.
    logic [63:0] mem [32];
    always @(posedge clk) begin
        if (buf_write_en) mem[buf_word_addr] <= buf_word_in;
        if (buf_read_en)  buf_word_out <= mem[buf_word_addr];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called right after raising a valid on a falling edge; returns #1 after the edge where ready is seen.
    task automatic wait_ready(input bit is_rd, input string tag);
        int n = 0;
        #1;
        while (!(is_rd ? rd_ready : ld_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_gnt"}, is_rd ? rd_ready : ld_ready, 1);
    endtask

    task automatic wr_op(input logic [4:0] addr, input logic [63:0] data, input string tag);
        @(negedge clk);
        ld_addr = addr; ld_data = data; ld_valid = 1'b1;
        wait_ready(1'b0, tag);
        chk({tag, "_rdy_excl"}, rd_ready, 0);
        @(posedge clk); #1 ld_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_we"}, buf_write_en, 1);
        chk({tag, "_re"}, buf_read_en, 0);
        chk({tag, "_waddr"}, buf_word_addr, addr);
        chk({tag, "_baddr"}, buf_byte_addr, {addr, 3'b000});
        chk({tag, "_wdata"}, buf_word_in, data);
        @(negedge clk);
        chk({tag, "_we_off"}, buf_write_en, 0);
    endtask

    task automatic rd_op(input logic mode, input logic [7:0] addr, input logic [63:0] exp, input string tag);
        @(negedge clk);
        rd_mode = mode; rd_addr = addr; rd_valid = 1'b1; rsp_ready = 1'b1;
        wait_ready(1'b1, tag);
        @(posedge clk); #1 rd_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_re"}, buf_read_en, 1);
        chk({tag, "_we"}, buf_write_en, 0);
        chk({tag, "_waddr"}, buf_word_addr, addr[7:3]);
        @(negedge clk);
        chk({tag, "_early"}, rsp_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_data, exp);
        @(negedge clk);
        chk({tag, "_done"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  seq;
        logic [63:0] held, first_rsp;
        int          ng, both, busy, stale;
        bit          got_rsp;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", buf_write_en, 0);
        chk("rst_re", buf_read_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("addr_mode", buf_addr_mode, 1);
        chk("byte_in", buf_byte_in, 0);
        rst = 1'b0;

        // 1-3: write then word and byte reads
        wr_op(5'd3, 64'h0123_4567_89AB_CDEF, "wr3");
        rd_op(1'b1, 8'h18, 64'h0123_4567_89AB_CDEF, "rdw18");
        rd_op(1'b0, 8'h1D, 64'h0000_0000_0000_0045, "rdb1d");
        rd_op(1'b0, 8'h18, 64'h0000_0000_0000_00EF, "rdb18");
        rd_op(1'b1, 8'h1F, 64'h0123_4567_89AB_CDEF, "rdw1f");

        // 4: both requesters held high; grants must alternate starting with the loader
        @(negedge clk);
        ld_addr = 5'd5; ld_data = 64'hA5A5_5A5A_DEAD_BEEF; ld_valid = 1'b1;
        rd_mode = 1'b1; rd_addr = 8'h28; rd_valid = 1'b1; rsp_ready = 1'b1;
        seq = '0; ng = 0; both = 0; got_rsp = 1'b0; first_rsp = '0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            #1;
            if (ld_ready && rd_ready) both++;
            if (rsp_valid && !got_rsp) begin got_rsp = 1'b1; first_rsp = rsp_data; end
            if (ld_ready)      begin seq = {seq[2:0], 1'b0}; ng++; end
            else if (rd_ready) begin seq = {seq[2:0], 1'b1}; ng++; end
            if (ng < 4) @(negedge clk);
        end
        @(posedge clk); #1 ld_valid = 1'b0; rd_valid = 1'b0;
        chk("tie_count", ng, 4);
        chk("tie_order", seq, 4'b0101);
        chk("tie_excl", both, 0);
        chk("tie_rd_data", first_rsp, 64'hA5A5_5A5A_DEAD_BEEF);
        repeat (6) @(negedge clk);

        // 5: response stalled; data stable and no readys while waiting
        @(negedge clk);
        rd_mode = 1'b1; rd_addr = 8'h18; rd_valid = 1'b1; rsp_ready = 1'b0;
        wait_ready(1'b1, "stall");
        @(posedge clk); #1 rd_valid = 1'b0;
        ld_addr = 5'd7; ld_data = 64'h1111_2222_3333_4444; ld_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("stall_valid0", rsp_valid, 1);
        held = rsp_data;
        chk("stall_data0", held, 64'h0123_4567_89AB_CDEF);
        busy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (!rsp_valid || rsp_data !== held || ld_ready || rd_ready) busy++;
        end
        chk("stall_hold", busy, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("stall_released", rsp_valid, 0);
        chk("stall_ld_after", ld_ready, 1);
        @(posedge clk); #1 ld_valid = 1'b0;
        @(negedge clk);
        chk("stall_ld_we", buf_write_en, 1);
        repeat (2) @(negedge clk);

        // 6: reset during CAPT drops the read
        @(negedge clk);
        rd_mode = 1'b1; rd_addr = 8'h18; rd_valid = 1'b1; rsp_ready = 1'b1;
        wait_ready(1'b1, "rstcapt");
        @(posedge clk); #1 rd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rstcapt_rsp_valid", rsp_valid, 0);
        chk("rstcapt_re", buf_read_en, 0);
        chk("rstcapt_we", buf_write_en, 0);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        chk("rstcapt_no_stale", stale, 0);
        ld_valid = 1'b1; rd_valid = 1'b1; ld_addr = 5'd9; rd_addr = 8'h48;
        #1;
        chk("rstcapt_tie_ld", ld_ready, 1);
        chk("rstcapt_tie_rd", rd_ready, 0);
        @(posedge clk); #1 ld_valid = 1'b0; rd_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset right after a loader grant must restore last_grant so the loader wins again
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 5'd10;
        #1;
        chk("lgrst_ld_gnt", ld_ready, 1);
        @(posedge clk); #1 ld_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("lgrst_we", buf_write_en, 0);
        ld_valid = 1'b1; rd_valid = 1'b1;
        #1;
        chk("lgrst_tie_ld", ld_ready, 1);
        chk("lgrst_tie_rd", rd_ready, 0);
        @(posedge clk); #1 ld_valid = 1'b0; rd_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
